// File: rtl/qspi_flash_reader.sv
// Quad-SPI flash reader: issues 0x6B (quad output fast read) with a serial
// address, clocks 8 dummy cycles, then streams 32-bit words to a requester.
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   qspi_enable          controller enable; low forces idle
//   qspi_address         start byte address of a new read
//   qspi_changeAddress   strobe starting a new read
//   qspi_requestData     requester wants more words
//   qspi_readData        last received word
//   qspi_readDataValid   one-cycle pulse with each new word
//   qspi_initialised     power-up delay complete
//   qspi_busy            command/address/dummy phase or mid-word
//   flash_csb, flash_sck chip select (active low) and serial clock
//   flash_io_oe/out/in   quad IO lines
module qspi_flash_reader #(
    parameter int ADDRESS_SIZE    = 24,
    parameter int POWER_UP_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    qspi_enable,
    input  logic [ADDRESS_SIZE-1:0] qspi_address,
    input  logic                    qspi_changeAddress,
    input  logic                    qspi_requestData,
    output logic [31:0]             qspi_readData,
    output logic                    qspi_readDataValid,
    output logic                    qspi_initialised,
    output logic                    qspi_busy,
    output logic                    flash_csb,
    output logic                    flash_sck,
    output logic [3:0]              flash_io_oe,
    output logic [3:0]              flash_io_out,
    input  logic [3:0]              flash_io_in
);

    typedef enum logic [2:0] {
        POWER_UP, IDLE, COMMAND, ADDRESS,
        DUMMY, DATA, HOLD, DESELECT
    } state_t;

    // Cycle counter must cover the address phase and at least 16 cycles.
    localparam int CW = (2 * ADDRESS_SIZE > 16) ? $clog2(2 * ADDRESS_SIZE) : 4;
    localparam int PW = (POWER_UP_CYCLES > 1) ? $clog2(POWER_UP_CYCLES) : 1;
    localparam logic [7:0] READ_CMD = 8'h6B;

    state_t stateReg;
    state_t stateNext;

    logic [CW-1:0]           cnt;
    logic [PW-1:0]           pwrCnt;
    logic [ADDRESS_SIZE-1:0] addrReg;
    logic [ADDRESS_SIZE-1:0] addrShift;
    logic [31:0]             shiftReg;
    logic                    wordDone;
    logic                    lastCycle;
    logic                    accept;

    always_comb begin
        lastCycle = 1'b0;
        unique case (stateReg)
            COMMAND, DUMMY, DATA: lastCycle = (cnt == CW'(15));
            ADDRESS:  lastCycle = (cnt == CW'(2 * ADDRESS_SIZE - 1));
            DESELECT: lastCycle = (cnt == CW'(1));
            default:  lastCycle = 1'b0;
        endcase
    end

    assign accept = qspi_enable && qspi_initialised
                    && !qspi_busy && qspi_changeAddress;

    // State register plus the datapath that follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg           <= POWER_UP;
            cnt                <= '0;
            pwrCnt             <= '0;
            addrReg            <= '0;
            addrShift          <= '0;
            shiftReg           <= '0;
            wordDone           <= 1'b0;
            qspi_readData      <= '0;
            qspi_readDataValid <= 1'b0;
            qspi_initialised   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            if (stateReg == POWER_UP) begin
                pwrCnt <= pwrCnt + PW'(1);
                if (stateNext == IDLE)
                    qspi_initialised <= 1'b1;
            end
            // Restart the count on every phase change and word boundary.
            if (stateNext != stateReg || lastCycle)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            if (accept)
                addrReg <= qspi_address;
            // Shift out one address bit at the end of each SCK-high cycle.
            if (stateReg == COMMAND)
                addrShift <= addrReg;
            else if (stateReg == ADDRESS && cnt[0])
                addrShift <= addrShift << 1;
            if (stateReg == DATA && qspi_enable && cnt[0])
                shiftReg <= {shiftReg[27:0], flash_io_in};
            wordDone <= (stateReg == DATA) && qspi_enable && lastCycle;
            qspi_readDataValid <= wordDone && qspi_enable;
            // First byte to arrive is the least significant.
            if (wordDone && qspi_enable)
                qspi_readData <= {shiftReg[7:0], shiftReg[15:8],
                                  shiftReg[23:16], shiftReg[31:24]};
        end
    end

    always_comb begin
        stateNext = stateReg;
        if (stateReg == POWER_UP) begin
            if (pwrCnt == PW'(POWER_UP_CYCLES - 1))
                stateNext = IDLE;
        end else if (!qspi_enable) begin
            stateNext = IDLE;
        end else begin
            unique case (stateReg)
                IDLE:     if (accept) stateNext = COMMAND;
                COMMAND:  if (lastCycle) stateNext = ADDRESS;
                ADDRESS:  if (lastCycle) stateNext = DUMMY;
                DUMMY:    if (lastCycle) stateNext = DATA;
                DATA: begin
                    if (lastCycle) begin
                        if (accept)
                            stateNext = DESELECT;
                        else if (!qspi_requestData)
                            stateNext = HOLD;
                    end
                end
                HOLD: begin
                    if (accept)
                        stateNext = DESELECT;
                    else if (qspi_requestData)
                        stateNext = DATA;
                end
                DESELECT: if (lastCycle) stateNext = COMMAND;
                default:  stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        flash_csb    = 1'b1;
        flash_sck    = 1'b0;
        flash_io_oe  = 4'b0000;
        flash_io_out = 4'b0000;
        qspi_busy    = 1'b0;
        unique case (stateReg)
            COMMAND: begin
                flash_csb       = 1'b0;
                flash_sck       = cnt[0];
                flash_io_oe     = 4'b0001;
                flash_io_out[0] = READ_CMD[~cnt[3:1]];
                qspi_busy       = 1'b1;
            end
            ADDRESS: begin
                flash_csb       = 1'b0;
                flash_sck       = cnt[0];
                flash_io_oe     = 4'b0001;
                flash_io_out[0] = addrShift[ADDRESS_SIZE-1];
                qspi_busy       = 1'b1;
            end
            DUMMY: begin
                flash_csb = 1'b0;
                flash_sck = cnt[0];
                qspi_busy = 1'b1;
            end
            DATA: begin
                flash_csb = 1'b0;
                flash_sck = cnt[0];
                qspi_busy = !lastCycle;
            end
            HOLD:     flash_csb = 1'b0;
            DESELECT: qspi_busy = 1'b1;
            default: begin
                flash_csb = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Testbench for qspi_flash_reader: behavioural quad flash model plus a
// scoreboard of expected words checked on every readDataValid pulse.
module tb_qspi_flash_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [23:0] addr;
    logic        chg;
    logic        req;
    logic [31:0] rd;
    logic        valid;
    logic        init;
    logic        busy;
    logic        csb;
    logic        sck;
    logic [3:0]  oe;
    logic [3:0]  ioOut;
    logic [3:0]  ioIn = 4'h0;

    qspi_flash_reader #(
        .ADDRESS_SIZE(24),
        .POWER_UP_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .qspi_enable(ena),
        .qspi_address(addr),
        .qspi_changeAddress(chg),
        .qspi_requestData(req),
        .qspi_readData(rd),
        .qspi_readDataValid(valid),
        .qspi_initialised(init),
        .qspi_busy(busy),
        .flash_csb(csb),
        .flash_sck(sck),
        .flash_io_oe(oe),
        .flash_io_out(ioOut),
        .flash_io_in(ioIn)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int validCnt = 0;
    int lastValidCyc = 0;
    int strobeCyc = 0;
    int csbHighCnt = 0;
    int csbLowCnt = 0;
    int validCycQ[$];
    logic [31:0] expQ[$];

    logic [7:0]  capCmd = 8'h00;
    logic [23:0] capAddr = 24'h0;
    int          bitCnt = 0;

    function automatic logic [7:0] mem(input logic [23:0] a);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = a[7:0] + 8'd1;
        hi = {4'h0, a[11:8]};
        return 8'(lo * 8'h11) + hi - 8'd1;
    endfunction

    function automatic logic [31:0] expWord(input logic [23:0] a);
        return {mem(a + 24'd3), mem(a + 24'd2), mem(a + 24'd1), mem(a)};
    endfunction

    always @(posedge clk) cyc++;

    // Flash model: one bit period completes on each SCK-high cycle.
    always @(negedge clk) begin
        if (csb) begin
            bitCnt = 0;
            capCmd = 8'h00;
            capAddr = 24'h0;
            ioIn = 4'h0;
        end else if (sck) begin
            if (bitCnt < 8)
                capCmd = {capCmd[6:0], ioOut[0]};
            else if (bitCnt < 32)
                capAddr = {capAddr[22:0], ioOut[0]};
            bitCnt++;
        end else if (bitCnt >= 40) begin
            int n;
            logic [7:0] b;
            n = bitCnt - 40;
            b = mem(capAddr + 24'(n / 2));
            ioIn = (n % 2 == 0) ? b[7:4] : b[3:0];
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (csb) csbHighCnt++;
        else csbLowCnt++;
        if (valid) begin
            validCnt++;
            lastValidCyc = cyc;
            validCycQ.push_back(cyc);
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid got=%h required=none", rd);
            end else begin
                logic [31:0] e;
                e = expQ.pop_front();
                if (rd !== e) begin
                    bad++;
                    $display("FAIL word got=%h required=%h", rd, e);
                end
            end
        end
    end

    task automatic strobe(input logic [23:0] a);
        @(negedge clk);
        addr = a;
        chg = 1'b1;
        @(posedge clk);
        #1;
        strobeCyc = cyc;
        csbHighCnt = 0;
        @(negedge clk);
        chg = 1'b0;
    endtask

    task automatic waitValid(input int target, output bit ok);
        int n;
        n = 0;
        while (validCnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = (validCnt >= target);
    endtask

    task automatic goIdle();
        @(negedge clk);
        ena = 1'b0;
        req = 1'b0;
        repeat (2) @(negedge clk);
        ena = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; ena = 1'b0; addr = '0; chg = 1'b0; req = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({csb, sck, oe, ioOut, rd, valid, init, busy} !==
            {1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got csb=%b sck=%b oe=%h rd=%h init=%b busy=%b required 1 0 0 0 0 0",
                     csb, sck, oe, rd, init, busy);
        end
        rst = 1'b0;
        csbLowCnt = 0;
        n = 0;
        while (!init && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL powerup_cycles got=%0d required=16", n);
        end
        @(negedge clk);
        total++;
        if (csbLowCnt !== 0) begin
            bad++;
            $display("FAIL powerup_csb low_cycles got=%0d required=0", csbLowCnt);
        end
        ena = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        int base;
        base = validCnt;
        req = 1'b0;
        expQ.push_back(expWord(24'h000100));
        strobe(24'h000100);
        waitValid(base + 1, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_timeout got=%0d required=%0d", validCnt, base + 1);
        end
        total++;
        if (lastValidCyc - strobeCyc !== 97) begin
            bad++;
            $display("FAIL single_latency got=%0d required=97", lastValidCyc - strobeCyc);
        end
        total++;
        if ({capCmd, capAddr} !== {8'h6B, 24'h000100}) begin
            bad++;
            $display("FAIL single_cmd_addr got=%h %h required=6b 000100", capCmd, capAddr);
        end
        repeat (3) @(negedge clk);
        total++;
        if ({csb, sck, busy} !== 3'b000) begin
            bad++;
            $display("FAIL single_hold got csb/sck/busy=%b%b%b required=000", csb, sck, busy);
        end
        goIdle();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base;
        base = validCnt;
        validCycQ.delete();
        req = 1'b1;
        expQ.push_back(expWord(24'h000100));
        expQ.push_back(expWord(24'h000104));
        expQ.push_back(expWord(24'h000108));
        strobe(24'h000100);
        waitValid(base + 2, ok);
        req = 1'b0;
        waitValid(base + 3, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL burst_timeout got=%0d required=%0d", validCnt, base + 3);
        end
        for (int i = 0; i < 3; i++) begin
            int got;
            got = (validCycQ.size() > i) ? validCycQ[i] - strobeCyc : -1;
            total++;
            if (got !== 97 + 16 * i) begin
                bad++;
                $display("FAIL burst_valid_cycle%0d got=%0d required=%0d", i, got, 97 + 16 * i);
            end
        end
        total++;
        if (csbHighCnt !== 0) begin
            bad++;
            $display("FAIL burst_csb high_cycles got=%0d required=0", csbHighCnt);
        end
        base = validCnt;
        repeat (40) @(negedge clk);
        total++;
        if (validCnt !== base || {csb, busy} !== 2'b00) begin
            bad++;
            $display("FAIL burst_stop got valids=%0d csb/busy=%b%b required=%0d 00",
                     validCnt, csb, busy, base);
        end
        goIdle();
    endtask

    task automatic test_hold();
        bit ok;
        int base;
        int viol;
        int rc;
        base = validCnt;
        req = 1'b0;
        expQ.push_back(expWord(24'h000100));
        strobe(24'h000100);
        waitValid(base + 1, ok);
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if ({csb, sck, busy} !== 3'b000) viol++;
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL hold_state bad_cycles got=%0d required=0", viol);
        end
        expQ.push_back(expWord(24'h000104));
        req = 1'b1;
        @(posedge clk);
        #1;
        rc = cyc;
        req = 1'b0;
        waitValid(base + 2, ok);
        total++;
        if (!ok || lastValidCyc - rc !== 17) begin
            bad++;
            $display("FAIL hold_resume_latency got=%0d required=17", lastValidCyc - rc);
        end
        goIdle();
    endtask

    task automatic test_strobe();
        bit ok;
        int base;
        base = validCnt;
        req = 1'b0;
        expQ.push_back(expWord(24'h000100));
        strobe(24'h000100);
        repeat (30) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL strobe_busy got=%b required=1", busy);
        end
        strobe(24'h000200);
        waitValid(base + 1, ok);
        total++;
        if (!ok || capAddr !== 24'h000100) begin
            bad++;
            $display("FAIL strobe_ignored got addr=%h required=000100", capAddr);
        end
        repeat (4) @(negedge clk);
        expQ.push_back(expWord(24'h000200));
        strobe(24'h000200);
        waitValid(base + 2, ok);
        total++;
        if (csbHighCnt !== 2) begin
            bad++;
            $display("FAIL deselect_cycles got=%0d required=2", csbHighCnt);
        end
        total++;
        if ({capCmd, capAddr} !== {8'h6B, 24'h000200}) begin
            bad++;
            $display("FAIL restart_cmd_addr got=%h %h required=6b 000200", capCmd, capAddr);
        end
        total++;
        if (!ok || lastValidCyc - strobeCyc !== 99) begin
            bad++;
            $display("FAIL restart_latency got=%0d required=99", lastValidCyc - strobeCyc);
        end
        goIdle();
    endtask

    task automatic test_abort();
        bit ok;
        int base;
        base = validCnt;
        req = 1'b1;
        expQ.push_back(expWord(24'h000100));
        strobe(24'h000100);
        waitValid(base + 1, ok);
        repeat (8) @(negedge clk);
        ena = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({csb, sck, oe, busy} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL enable_abort got csb=%b sck=%b oe=%h busy=%b required 1 0 0 0",
                     csb, sck, oe, busy);
        end
        base = validCnt;
        repeat (40) @(negedge clk);
        total++;
        if (validCnt !== base) begin
            bad++;
            $display("FAIL enable_abort_valid got=%0d required=%0d", validCnt, base);
        end
        ena = 1'b1;
        req = 1'b0;
        strobe(24'h000100);
        repeat (70) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({csb, sck, oe, ioOut, rd, valid, init, busy} !==
            {1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rst_abort got csb=%b sck=%b oe=%h rd=%h init=%b busy=%b required 1 0 0 0 0 0",
                     csb, sck, oe, rd, init, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        base = validCnt;
        repeat (100) @(negedge clk);
        total++;
        if (validCnt !== base || init !== 1'b1 || csb !== 1'b1) begin
            bad++;
            $display("FAIL rst_recover got valids=%0d init=%b csb=%b required=%0d 1 1",
                     validCnt, init, csb, base);
        end
        total++;
        if (expQ.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d required=0", expQ.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_strobe();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qspi_flash_reader.md
QSPI_FLASH_READER -- requirements
Module: qspi_flash_reader

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 24: flash byte-address width.
REQ-002 SHALL have parameter POWER_UP_CYCLES, default 1024: clk cycles from reset release to initialised.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port qspi_enable  input  1  controller enable; low forces idle.
REQ-006 SHALL have port qspi_address  input  ADDRESS_SIZE  start byte address, word aligned.
REQ-007 SHALL have port qspi_changeAddress  input  1  one-cycle strobe starting a new read at qspi_address.
REQ-008 SHALL have port qspi_requestData  input  1  requester wants further words.
REQ-009 SHALL have port qspi_readData  output  32  last received word.
REQ-010 SHALL have port qspi_readDataValid  output  1  one-cycle pulse, qspi_readData valid.
REQ-011 SHALL have port qspi_initialised  output  1  power-up delay complete.
REQ-012 SHALL have port qspi_busy  output  1  command/address/dummy phase or mid-word.
REQ-013 SHALL have ports flash_csb  output  1  chip select, active-low; flash_sck  output  1  serial clock.
REQ-014 SHALL have ports flash_io_oe  output  4, flash_io_out  output  4, flash_io_in  input  4  quad IO lines.

Function
REQ-015 SHALL implement states POWER_UP, IDLE, COMMAND, ADDRESS, DUMMY, DATA, HOLD, DESELECT.
REQ-016 SHALL count POWER_UP_CYCLES in POWER_UP, then set qspi_initialised=1 and enter IDLE; initialised stays 1 until rst.
REQ-017 SHALL run flash_sck at clk/2: each bit period = 2 clk cycles, SCK low in first, high in second; SCK held low outside active bit periods.
REQ-018 SHALL change flash_io_out only at bit-period start; SHALL sample flash_io_in on the clk edge ending the SCK-high cycle.
REQ-019 SHALL accept qspi_changeAddress only when qspi_enable && qspi_initialised && !qspi_busy; otherwise ignore it, no latching.
REQ-020 SHALL latch qspi_address on an accepted strobe; if in IDLE, next cycle drive flash_csb=0 and enter COMMAND.
REQ-021 SHALL on an accepted strobe in HOLD or DATA word boundary enter DESELECT: flash_csb=1 for 2 cycles, then COMMAND.
REQ-022 COMMAND SHALL send 8'h6B MSB-first on IO0 only (oe=4'b0001), 16 cycles.
REQ-023 ADDRESS SHALL send latched address MSB-first on IO0, ADDRESS_SIZE*2 cycles.
REQ-024 DUMMY SHALL clock 8 bit periods (16 cycles) with flash_io_oe=4'b0000.
REQ-025 DATA SHALL receive 8 nibbles (16 cycles) per word, oe=0; byte n (arrival order 0..3) -> qspi_readData[8n+7:8n], high nibble first per byte.
REQ-026 SHALL pulse qspi_readDataValid in the cycle after the 8th nibble is sampled, with qspi_readData updated in that same cycle and held until the next word.
REQ-027 With ADDRESS_SIZE=24 the first readDataValid SHALL occur exactly 97 cycles after the edge sampling an accepted strobe from IDLE.
REQ-028 At each word boundary SHALL continue DATA back-to-back (next valid 16 cycles later) if qspi_requestData=1, else enter HOLD with flash_csb=0, SCK low.
REQ-029 HOLD SHALL resume DATA the cycle after qspi_requestData=1; the flash address continues sequentially.
REQ-030 qspi_busy SHALL be 1 in COMMAND, ADDRESS, DUMMY, DESELECT and in DATA except the word-boundary cycle; 0 in POWER_UP, IDLE, HOLD.
REQ-031 qspi_enable=0 SHALL within 1 cycle force flash_csb=1, oe=0, SCK=0, abort any word without readDataValid, enter IDLE.
REQ-032 Strobe and requestData=0 at the same boundary: strobe wins (DESELECT).

Reset
REQ-033 On rst: state POWER_UP, counter 0, flash_csb=1, flash_sck=0, flash_io_oe=0, flash_io_out=0, qspi_readData=0, qspi_readDataValid=0, qspi_initialised=0, qspi_busy=0; rst mid-transfer aborts immediately.

Verification
REQ-034 Release rst, POWER_UP_CYCLES=16 -> qspi_initialised rises 16 cycles later; flash_csb stays 1 throughout.
REQ-035 Strobe address 24'h000100 from IDLE, model returns bytes 11,22,33,44 -> IO0 shows 6B then 000100; valid at cycle 97, readData=32'h44332211.
REQ-036 requestData held 1 for 3 words -> valid pulses at cycles 97, 113, 129, sequential data, csb low continuously.
REQ-037 requestData=0 after word 1, re-asserted 20 cycles later -> HOLD with SCK low, busy=0; word 2 valid 17 cycles after re-assert.
REQ-038 Strobe while busy (in ADDRESS) -> ignored; strobe in HOLD with 24'h000200 -> csb high 2 cycles, new command 6B 000200.
REQ-039 qspi_enable dropped mid-word, and rst mid-DUMMY -> csb=1 next cycle, no valid pulse, outputs at reset/idle values.
